// File: rtl/uart_arb_pkg.sv
// Shared types and widths for the UART TX round-robin arbiter.
package uart_arb_pkg;

    localparam int unsigned ID_W   = 3;
    localparam int unsigned WDOG_W = 24;
    localparam int unsigned GAP_W  = 8;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_e;

    // Latched grant: who won and the byte being transmitted.
    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [BYTE_W-1:0] data;
    } grant_t;

    // Round-robin pointer advance: one past the winner, wrapping at n.
    function automatic logic [ID_W-1:0] rr_next(input logic [ID_W-1:0] cur,
                                               input int unsigned     n);
        return (32'(cur) == n - 1) ? '0 : cur + ID_W'(1);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and UART-side signals of the TX arbiter.
// slave = arbiter view, master = requesters/UART/monitor view.
interface uart_tx_arbiter_if
    import uart_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) ();

    logic [NUM_REQ-1:0]        req_valid;
    logic [BYTE_W*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ack;
    logic                      uart_tx_req;
    logic [BYTE_W-1:0]         uart_tx_data;
    logic                      uart_tx_ready;
    logic [ID_W-1:0]           grant_id;
    logic                      busy;
    logic                      timeout_err;

    modport slave (
        input  req_valid, req_data, uart_tx_ready,
        output req_ack, uart_tx_req, uart_tx_data, grant_id, busy, timeout_err
    );

    modport master (
        output req_valid, req_data, uart_tx_ready,
        input  req_ack, uart_tx_req, uart_tx_data, grant_id, busy, timeout_err
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid at or after ptr, wrapping.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [ID_W-1:0]    winner_c_o,
    output logic               any_valid_c_o
);

    // Scan offsets from farthest to nearest so the nearest valid wins.
    always_comb begin
        winner_c_o    = '0;
        any_valid_c_o = |valid_i;
        for (int unsigned k = NUM_REQ; k > 0; k--) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (valid_i[i] && (i == (32'(ptr_i) + k - 1) % NUM_REQ)) begin
                    winner_c_o = ID_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte sources.
// Optional watchdog on a lost tx_ready: define ARB_TX_TIMEOUT_EN.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned GAP_CYCLES     = 2
`ifdef ARB_TX_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
`endif
) (
    input  logic              clk,
    input  logic              reset_n,
    uart_tx_arbiter_if.slave  bus
);

    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

    arb_state_e          state_q;
    logic [GAP_W-1:0]    gap_q;
    logic [ID_W-1:0]     ptr_q;
    grant_t              grant_q;
    logic                tx_req_q;
    logic [NUM_REQ-1:0]  ack_q;
    logic                busy_q;
    logic                tout_q;

    logic [ID_W-1:0]     winner;
    logic                any_valid;
    logic [BYTE_W-1:0]   win_byte;
    logic [NUM_REQ-1:0]  win_onehot;
    logic                wdog_hit;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .valid_i       (bus.req_valid),
        .ptr_i         (ptr_q),
        .winner_c_o    (winner),
        .any_valid_c_o (any_valid)
    );

    // Select the winner's byte and build its ack one-hot.
    always_comb begin
        win_byte   = '0;
        win_onehot = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (winner == ID_W'(i)) begin
                win_byte      = bus.req_data[BYTE_W*i +: BYTE_W];
                win_onehot[i] = 1'b1;
            end
        end
    end

`ifdef ARB_TX_TIMEOUT_EN
    logic [WDOG_W-1:0] wdog_q;

    // Watchdog: cleared on SEND entry, counts every clock spent in SEND.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wdog_q <= '0;
        end else if (state_q == ST_IDLE) begin
            wdog_q <= '0;
        end else if (state_q == ST_SEND) begin
            wdog_q <= wdog_q + WDOG_W'(1);
        end
    end

    assign wdog_hit = (state_q == ST_SEND) && (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1));
`else
    assign wdog_hit = 1'b0;
`endif

    // Arbiter FSM with registered UART, ack and status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_GAP;
            gap_q    <= GAP_LOAD;
            ptr_q    <= '0;
            grant_q  <= '0;
            tx_req_q <= 1'b0;
            ack_q    <= '0;
            busy_q   <= 1'b1;
            tout_q   <= 1'b0;
        end else begin
            ack_q  <= '0;
            tout_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (any_valid) begin
                        grant_q.id   <= winner;
                        grant_q.data <= win_byte;
                        ack_q        <= win_onehot;
                        ptr_q        <= rr_next(winner, NUM_REQ);
                        tx_req_q     <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (bus.uart_tx_ready || wdog_hit) begin
                        tx_req_q <= 1'b0;
                        tout_q   <= !bus.uart_tx_ready;
                        gap_q    <= GAP_LOAD;
                        state_q  <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_q == '0) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        gap_q <= gap_q - GAP_W'(1);
                    end
                end
                default: begin
                    tx_req_q <= 1'b0;
                    gap_q    <= GAP_LOAD;
                    state_q  <= ST_GAP;
                end
            endcase
        end
    end

    assign bus.req_ack      = ack_q;
    assign bus.uart_tx_req  = tx_req_q;
    assign bus.uart_tx_data = grant_q.data;
    assign bus.grant_id     = grant_q.id;
    assign bus.busy         = busy_q;
    assign bus.timeout_err  = tout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: vector table + scoreboard + behavioural UART.
module tb_uart_tx_arbiter;
    import uart_arb_pkg::*;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned GAP   = 2;
    localparam int unsigned FRAME = 100;
    localparam int unsigned TOUT  = 50;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(NREQ)) u_if ();

    uart_tx_arbiter #(
        .NUM_REQ        (NREQ),
        .GAP_CYCLES     (GAP)
`ifdef ARB_TX_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (TOUT)
`endif
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (u_if.slave)
    );

    // Behavioural UART: ready pulse ~FRAME clocks after each tx_req rise.
    logic        suppress = 1'b0;
    int unsigned m_cnt;
    logic        m_active;
    logic        m_prev;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_cnt               <= 0;
            m_active            <= 1'b0;
            m_prev              <= 1'b0;
            u_if.uart_tx_ready  <= 1'b0;
        end else begin
            u_if.uart_tx_ready <= 1'b0;
            m_prev             <= u_if.uart_tx_req;
            if (u_if.uart_tx_req && !m_prev) begin
                m_active <= !suppress;
                m_cnt    <= 1;
            end else if (m_active) begin
                if (m_cnt == FRAME - 1) begin
                    u_if.uart_tx_ready <= 1'b1;
                    m_active           <= 1'b0;
                end else begin
                    m_cnt <= m_cnt + 1;
                end
            end
        end
    end

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic [2:0]  id;
        logic [7:0]  bval;
    } vec_t;

    int     errors = 0;
    int     checks = 0;
    grant_t sb[$];

    logic        prev_req  = 1'b0;
    logic [7:0]  prev_data = '0;
    int unsigned low_cnt   = 0;
    bit          first_rise    = 1'b1;
    bit          rose          = 1'b0;
    bit          tout_expected = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock; sample after the edge and run the protocol monitor.
    task automatic tick();
        grant_t e;
        @(posedge clk);
        #1;
        rose = u_if.uart_tx_req && !prev_req;
        if (rose) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_grant: grant_id %0d data 0x%0h, scoreboard empty",
                         u_if.grant_id, u_if.uart_tx_data);
            end else begin
                e = sb.pop_front();
                chk("grant_id", 32'(u_if.grant_id), 32'(e.id));
                chk("tx_data", 32'(u_if.uart_tx_data), 32'(e.data));
                chk("ack_onehot", 32'(u_if.req_ack), 32'(1) << e.id);
            end
            if (!first_rise) begin
                checks++;
                if (low_cnt < GAP + 1) begin
                    errors++;
                    $display("FAIL gap_low_cycles: got %0d required >= %0d", low_cnt, GAP + 1);
                end
            end
            first_rise = 1'b0;
        end else if (u_if.req_ack !== '0) begin
            checks++;
            errors++;
            $display("FAIL spurious_ack: got 0x%0h expected 0", u_if.req_ack);
        end
        if (u_if.uart_tx_req && prev_req && (u_if.uart_tx_data !== prev_data)) begin
            checks++;
            errors++;
            $display("FAIL data_unstable: got 0x%0h expected 0x%0h", u_if.uart_tx_data, prev_data);
        end
        if (u_if.timeout_err === 1'b1 && !tout_expected) begin
            checks++;
            errors++;
            $display("FAIL unexpected_timeout: timeout_err=1 expected 0");
        end
        low_cnt   = u_if.uart_tx_req ? 0 : low_cnt + 1;
        prev_req  = u_if.uart_tx_req;
        prev_data = u_if.uart_tx_data;
    endtask

    task automatic wait_rise(input int unsigned budget, input string what);
        int unsigned n = 0;
        do begin
            tick();
            n++;
        end while (!rose && n < budget);
        if (!rose) begin
            checks++;
            errors++;
            $display("FAIL %s: no tx_req rise within %0d clocks", what, budget);
        end
    endtask

    // Wait for end of frame, then check busy drops GAP clocks after tx_req falls.
    task automatic finish_frame(input string what);
        int unsigned n = 0;
        while (u_if.uart_tx_req && n < FRAME + 50) begin
            tick();
            n++;
        end
        if (u_if.uart_tx_req) begin
            checks++;
            errors++;
            $display("FAIL %s_fall: tx_req still 1 after %0d clocks, expected 0", what, n);
        end
        n = 0;
        while (u_if.busy && n < 20) begin
            tick();
            n++;
        end
        chk({what, "_busy_gap"}, n, GAP);
        chk({what, "_req_low"}, 32'(u_if.uart_tx_req), 0);
    endtask

    initial begin : main
        vec_t vecs[10];
        int unsigned n;
        vecs[0] = '{4'b0001, 32'h000000A5, 3'd0, 8'hA5};
        vecs[1] = '{4'b1111, 32'h13121110, 3'd1, 8'h11};
        vecs[2] = '{4'b1111, 32'h23222120, 3'd2, 8'h22};
        vecs[3] = '{4'b1111, 32'h33323130, 3'd3, 8'h33};
        vecs[4] = '{4'b1001, 32'h43424140, 3'd0, 8'h40};
        vecs[5] = '{4'b1001, 32'h53525150, 3'd3, 8'h53};
        vecs[6] = '{4'b0100, 32'h63626160, 3'd2, 8'h62};
        vecs[7] = '{4'b0011, 32'h73727170, 3'd0, 8'h70};
        vecs[8] = '{4'b0001, 32'h83828180, 3'd0, 8'h80};
        vecs[9] = '{4'b0110, 32'h93929190, 3'd1, 8'h91};

        u_if.req_valid = '0;
        u_if.req_data  = '0;

        // Reset values
        repeat (3) tick();
        chk("rst_tx_req", 32'(u_if.uart_tx_req), 0);
        chk("rst_tx_data", 32'(u_if.uart_tx_data), 0);
        chk("rst_ack", 32'(u_if.req_ack), 0);
        chk("rst_grant", 32'(u_if.grant_id), 0);
        chk("rst_timeout", 32'(u_if.timeout_err), 0);
        chk("rst_busy", 32'(u_if.busy), 1);
        reset_n = 1'b1;

        // Table: single bytes, rotation, pointer wrap, sparse valids
        for (int v = 0; v < 10; v++) begin
            sb.push_back('{id: vecs[v].id, data: vecs[v].bval});
            u_if.req_valid = vecs[v].valid;
            u_if.req_data  = vecs[v].data;
            wait_rise(40, "vec_grant");
            u_if.req_valid = '0;
            finish_frame("vec");
        end

        // Continuous contention: pointer is at 2 here
        u_if.req_data = 32'h13121110;
        for (int k = 0; k < 8; k++) begin
            sb.push_back('{id: 3'((k + 2) % 4), data: 8'(8'h10 + (k + 2) % 4)});
        end
        u_if.req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            wait_rise(FRAME + GAP + 30, "contention_grant");
        end
        u_if.req_valid = '0;
        finish_frame("contention");
        chk("contention_sb_empty", 32'(sb.size()), 0);

        // Reset in the middle of a frame (pointer at 2 -> requester 3 wins)
        sb.push_back('{id: 3'd3, data: 8'h13});
        u_if.req_valid = 4'b1000;
        wait_rise(40, "pre_reset_grant");
        repeat (50) tick();
        u_if.req_valid = 4'b1111;
        reset_n = 1'b0;
        #1;
        chk("midrst_tx_req", 32'(u_if.uart_tx_req), 0);
        chk("midrst_busy", 32'(u_if.busy), 1);
        chk("midrst_grant", 32'(u_if.grant_id), 0);
        chk("midrst_ack", 32'(u_if.req_ack), 0);
        repeat (3) tick();
        sb.push_back('{id: 3'd0, data: 8'h10});
        first_rise = 1'b1;
        reset_n = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!rose && n < 40);
        chk("post_reset_latency", n, GAP + 1);
        u_if.req_valid = '0;
        finish_frame("post_reset");

`ifdef ARB_TX_TIMEOUT_EN
        // Watchdog: lost tx_ready (pointer at 1)
        suppress = 1'b1;
        sb.push_back('{id: 3'd1, data: 8'h11});
        u_if.req_valid = 4'b0010;
        wait_rise(40, "wdog_grant");
        u_if.req_valid = '0;
        tout_expected = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (u_if.timeout_err !== 1'b1 && n < TOUT + 20);
        chk("wdog_latency", n, TOUT);
        chk("wdog_tx_req", 32'(u_if.uart_tx_req), 0);
        tick();
        chk("wdog_pulse_len", 32'(u_if.timeout_err), 0);
        tout_expected = 1'b0;
        suppress = 1'b0;
        n = 0;
        while (u_if.busy && n < 20) begin
            tick();
            n++;
        end
        sb.push_back('{id: 3'd2, data: 8'h12});
        u_if.req_valid = 4'b0110;
        wait_rise(40, "wdog_next_grant");
        u_if.req_valid = '0;
        finish_frame("wdog_next");
`else
        // No watchdog: SEND is held while tx_ready never comes
        suppress = 1'b1;
        sb.push_back('{id: 3'd1, data: 8'h11});
        u_if.req_valid = 4'b0010;
        wait_rise(40, "hold_grant");
        u_if.req_valid = '0;
        repeat (300) tick();
        chk("hold_tx_req", 32'(u_if.uart_tx_req), 1);
        chk("hold_busy", 32'(u_if.busy), 1);
        chk("hold_timeout", 32'(u_if.timeout_err), 0);
        reset_n = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        suppress = 1'b0;
        repeat (2) tick();
`endif

        chk("final_sb_empty", 32'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : global_guard
        #5000000;
        $display("FAIL global_timeout: bench did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
